// File: rtl/parking_access_controller_if.sv
// Request/response bundle of the parking access controller.
// The fee field exists only when SMART_PARKING_FEE_EN is defined.
interface parking_access_controller_if #(
    parameter int TIME_W = 8
);
    logic              entry_req;
    logic              exit_req;
    logic [2:0]        exit_token;
    logic [2:0]        pattern;
    logic              busy;
    logic              resp_valid;
    logic              resp_type;
    logic              resp_ok;
    logic [2:0]        token_out;
    logic [TIME_W-1:0] time_total;
    logic [7:0]        occupancy;
    logic [3:0]        parked;
    logic [3:0]        empty;
`ifdef SMART_PARKING_FEE_EN
    logic [11:0]       fee;
`endif

    // Requester side: drives gate requests, observes responses and counts
    modport master (
        output entry_req, exit_req, exit_token, pattern,
        input  busy, resp_valid, resp_type, resp_ok, token_out, time_total,
               occupancy, parked, empty
`ifdef SMART_PARKING_FEE_EN
               , fee
`endif
    );

    // Controller side
    modport slave (
        input  entry_req, exit_req, exit_token, pattern,
        output busy, resp_valid, resp_type, resp_ok, token_out, time_total,
               occupancy, parked, empty
`ifdef SMART_PARKING_FEE_EN
               , fee
`endif
    );
endinterface

// File: rtl/parking_access_controller.sv
// Parking access controller: captures entry/exit gate pulses, arbitrates them
// round-robin onto one allocate/release engine, owns the 8-slot occupancy map,
// timestamps entries and reports parked duration on exit.
// Optional build macro SMART_PARKING_FEE_EN adds a saturating fee output.
module parking_access_controller #(
    parameter int TIME_W    = 8,
    parameter bit PRIO_INIT = 1'b0,
    parameter int FEE_RATE  = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        tick,
    parking_access_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        EXIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [TIME_W-1:0] TIME_ONE = 1;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_take_entry;
    logic              w_take_exit;
    logic              w_collide;

    logic              r_pend_entry;
    logic              r_pend_exit;
    logic              r_prio;
    logic [2:0]        r_exit_token;
    logic [TIME_W-1:0] r_time;
    logic [TIME_W-1:0] r_entry_time [8];
    logic [7:0]        r_occ;
    logic [3:0]        r_parked;
    logic [3:0]        r_empty;

    logic              r_resp_type;
    logic              r_resp_ok;
    logic [2:0]        r_token;
    logic [TIME_W-1:0] r_total;
`ifdef SMART_PARKING_FEE_EN
    logic [11:0]       r_fee;
`endif

    logic [2:0]        w_free_slot;
    logic              w_full;
    logic [2:0]        w_exit_slot;
    logic              w_exit_hit;
    logic [TIME_W-1:0] w_duration;
    logic              w_do_entry;
    logic              w_do_exit;
    logic [7:0]        w_occ_next;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    // Duration times rate, clamped to the 12-bit fee range
    function automatic logic [11:0] sat_fee(input logic [TIME_W-1:0] d);
        logic [31:0] prod;
        prod = 32'(d) * 32'(FEE_RATE);
        return (prod > 32'd4095) ? 12'hFFF : prod[11:0];
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // Next state: while idle pick a pending request, round-robin on collision
    always_comb begin
        w_state_next = r_state;
        w_take_entry = 1'b0;
        w_take_exit  = 1'b0;
        w_collide    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend_entry && r_pend_exit) begin
                    w_collide = 1'b1;
                    if (r_prio) w_take_exit  = 1'b1;
                    else        w_take_entry = 1'b1;
                end else begin
                    w_take_entry = r_pend_entry;
                    w_take_exit  = r_pend_exit;
                end
                if (w_take_entry)     w_state_next = ENTRY;
                else if (w_take_exit) w_state_next = EXIT;
            end
            ENTRY, EXIT: w_state_next = RESP;
            default:     w_state_next = IDLE;
        endcase
    end

    // Lowest-index free slot for a new car
    always_comb begin
        w_free_slot = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!r_occ[i]) w_free_slot = 3'(i);
        end
    end

    assign w_full      = &r_occ;
    assign w_exit_slot = r_exit_token ^ bus.pattern;
    assign w_exit_hit  = r_occ[w_exit_slot];
    assign w_duration  = r_time - r_entry_time[w_exit_slot];
    assign w_do_entry  = (r_state == ENTRY) && !w_full;
    assign w_do_exit   = (r_state == EXIT) && w_exit_hit;

    // Occupancy after this cycle's allocate or release
    always_comb begin
        w_occ_next = r_occ;
        if (w_do_entry) w_occ_next[w_free_slot] = 1'b1;
        if (w_do_exit)  w_occ_next[w_exit_slot] = 1'b0;
    end

    // Request capture (new pulse beats the clear), time base and priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_entry <= 1'b0;
            r_pend_exit  <= 1'b0;
            r_exit_token <= 3'd0;
            r_time       <= '0;
            r_prio       <= PRIO_INIT;
        end else begin
            r_pend_entry <= bus.entry_req | (r_pend_entry & ~w_take_entry);
            r_pend_exit  <= bus.exit_req  | (r_pend_exit  & ~w_take_exit);
            if (bus.exit_req) r_exit_token <= bus.exit_token;
            if (tick)         r_time <= r_time + TIME_ONE;
            if (w_collide)    r_prio <= ~r_prio;
        end
    end

    // Slot map, entry timestamps and registered counts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ    <= 8'd0;
            r_parked <= 4'd0;
            r_empty  <= 4'd8;
            for (int i = 0; i < 8; i++) r_entry_time[i] <= '0;
        end else begin
            r_occ    <= w_occ_next;
            r_parked <= popcount8(w_occ_next);
            r_empty  <= 4'd8 - popcount8(w_occ_next);
            if (w_do_entry) r_entry_time[w_free_slot] <= r_time;
        end
    end

    // Response fields, loaded when a request is serviced and held until the next
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_type <= 1'b0;
            r_resp_ok   <= 1'b0;
            r_token     <= 3'd0;
            r_total     <= '0;
`ifdef SMART_PARKING_FEE_EN
            r_fee       <= 12'd0;
`endif
        end else if (r_state == ENTRY) begin
            r_resp_type <= 1'b0;
            r_resp_ok   <= !w_full;
            r_token     <= w_full ? 3'd0 : (w_free_slot ^ bus.pattern);
            r_total     <= '0;
`ifdef SMART_PARKING_FEE_EN
            r_fee       <= 12'd0;
`endif
        end else if (r_state == EXIT) begin
            r_resp_type <= 1'b1;
            r_resp_ok   <= w_exit_hit;
            r_token     <= 3'd0;
            r_total     <= w_exit_hit ? w_duration : '0;
`ifdef SMART_PARKING_FEE_EN
            r_fee       <= w_exit_hit ? sat_fee(w_duration) : 12'd0;
`endif
        end
    end

    assign bus.busy       = (r_state != IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_type  = r_resp_type;
    assign bus.resp_ok    = r_resp_ok;
    assign bus.token_out  = r_token;
    assign bus.time_total = r_total;
    assign bus.occupancy  = r_occ;
    assign bus.parked     = r_parked;
    assign bus.empty      = r_empty;
`ifdef SMART_PARKING_FEE_EN
    assign bus.fee        = r_fee;
`endif

endmodule

// File: tb/tb_parking_access_controller.sv
// Bench for parking_access_controller: directed gate traffic, a transaction
// level model of slots/times/response schedule checked every cycle, and a
// table of hand-computed responses.
module tb_parking_access_controller;
    localparam int TIME_W   = 8;
    localparam int FEE_RATE = 3;
    localparam int N_RESP   = 19;

    logic clk;
    logic reset_n;
    logic tick;

    parking_access_controller_if #(.TIME_W(TIME_W)) bus_if ();

    parking_access_controller #(
        .TIME_W(TIME_W),
        .PRIO_INIT(1'b0),
        .FEE_RATE(FEE_RATE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tick(tick),
        .bus(bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Hand-computed responses in service order
    int lit_type [N_RESP] = '{0,0,0,0,0,0,0,0,0, 0,1, 0,1, 0,1,1,0, 0,1};
    int lit_ok   [N_RESP] = '{1,1,1,1,1,1,1,1,0, 1,1, 1,0, 1,1,0,1, 1,1};
    int lit_val  [N_RESP] = '{5,4,7,6,1,0,3,2,0, 0,25, 0,0, 0,0,0,0, 0,10};
    int lit_occ  [N_RESP] = '{8'h01,8'h03,8'h07,8'h0F,8'h1F,8'h3F,8'h7F,8'hFF,8'hFF,
                              8'h01,8'h00, 8'h01,8'h01, 8'h01,8'h00,8'h00,8'h01,
                              8'h01,8'h00};
    int lit_fee  [N_RESP] = '{0,0,0,0,0,0,0,0,0, 0,75, 0,0, 0,0,0,0, 0,30};

    typedef struct {
        bit         is_exit;
        logic [2:0] tok;
        int         exp;
    } txn_t;

    txn_t       q[$];
    logic [7:0] m_occ;
    int         m_etime [8];
    int         m_time;
    int         m_tlast;
    bit         m_prio;
    int         m_last;
    int         cyc = 0;
    int         resp_idx = 0;
    bit         done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic enqueue(input bit is_exit, input logic [2:0] tok);
        txn_t t;
        t.is_exit = is_exit;
        t.tok     = tok;
        t.exp     = (cyc + 3 > m_last + 3) ? cyc + 3 : m_last + 3;
        m_last    = t.exp;
        q.push_back(t);
    endtask

    // Model update and comparison, once per cycle away from the active edge
    always @(negedge clk) begin : cmp
        txn_t t;
        int   svc, s, e_ok, e_val, e_fee;
        bit   exp_valid, exp_busy;
        cyc++;
        if (!reset_n) begin
            q.delete();
            m_occ  = 8'd0;
            for (int i = 0; i < 8; i++) m_etime[i] = 0;
            m_time  = 0;
            m_tlast = 0;
            m_prio  = 1'b0;
            m_last  = -100;
            chk("rst_resp_valid", 32'(bus_if.resp_valid), 0);
            chk("rst_busy",       32'(bus_if.busy), 0);
            chk("rst_occupancy",  32'(bus_if.occupancy), 0);
            chk("rst_parked",     32'(bus_if.parked), 0);
            chk("rst_empty",      32'(bus_if.empty), 8);
            chk("rst_resp_ok",    32'(bus_if.resp_ok), 0);
            chk("rst_token_out",  32'(bus_if.token_out), 0);
            chk("rst_time_total", 32'(bus_if.time_total), 0);
`ifdef SMART_PARKING_FEE_EN
            chk("rst_fee",        32'(bus_if.fee), 0);
`endif
        end else begin
            svc       = m_tlast;
            exp_valid = (q.size() > 0) && (q[0].exp == cyc);
            exp_busy  = (q.size() > 0) && (cyc >= q[0].exp - 1);
            chk("resp_valid", 32'(bus_if.resp_valid), 32'(exp_valid));
            if (exp_valid) begin
                t = q.pop_front();
                e_fee = 0;
                if (!t.is_exit) begin
                    if (m_occ == 8'hFF) begin
                        e_ok = 0; e_val = 0;
                    end else begin
                        s = 0;
                        while (m_occ[s]) s++;
                        m_occ[s]   = 1'b1;
                        m_etime[s] = svc;
                        e_ok  = 1;
                        e_val = s ^ int'(bus_if.pattern);
                    end
                end else begin
                    s = int'(t.tok ^ bus_if.pattern);
                    if (m_occ[s]) begin
                        e_ok  = 1;
                        e_val = (svc - m_etime[s] + 256) % 256;
                        e_fee = (e_val * FEE_RATE > 4095) ? 4095 : e_val * FEE_RATE;
                        m_occ[s] = 1'b0;
                    end else begin
                        e_ok = 0; e_val = 0;
                    end
                end
                chk("resp_type", 32'(bus_if.resp_type), 32'(t.is_exit));
                chk("resp_ok",   32'(bus_if.resp_ok), 32'(e_ok));
                if (!t.is_exit) chk("token_out",  32'(bus_if.token_out), 32'(e_val));
                else            chk("time_total", 32'(bus_if.time_total), 32'(e_val));
`ifdef SMART_PARKING_FEE_EN
                chk("fee", 32'(bus_if.fee), 32'(e_fee));
`endif
                if (resp_idx < N_RESP) begin
                    chk("lit_type", 32'(bus_if.resp_type), 32'(lit_type[resp_idx]));
                    chk("lit_ok",   32'(bus_if.resp_ok), 32'(lit_ok[resp_idx]));
                    if (lit_type[resp_idx] == 0)
                        chk("lit_token", 32'(bus_if.token_out), 32'(lit_val[resp_idx]));
                    else
                        chk("lit_time", 32'(bus_if.time_total), 32'(lit_val[resp_idx]));
                    chk("lit_occupancy", 32'(bus_if.occupancy), 32'(lit_occ[resp_idx]));
`ifdef SMART_PARKING_FEE_EN
                    chk("lit_fee", 32'(bus_if.fee), 32'(lit_fee[resp_idx]));
`endif
                end else begin
                    chk("extra_response", 32'(resp_idx), 32'(N_RESP - 1));
                end
                resp_idx++;
            end
            chk("occupancy", 32'(bus_if.occupancy), 32'(m_occ));
            chk("parked",    32'(bus_if.parked), 32'($countones(m_occ)));
            chk("empty",     32'(bus_if.empty), 32'(8 - $countones(m_occ)));
            chk("busy",      32'(bus_if.busy), 32'(exp_busy));
            if (bus_if.entry_req && bus_if.exit_req) begin
                if (m_prio) begin
                    enqueue(1'b1, bus_if.exit_token);
                    enqueue(1'b0, 3'd0);
                end else begin
                    enqueue(1'b0, 3'd0);
                    enqueue(1'b1, bus_if.exit_token);
                end
                m_prio = !m_prio;
            end else if (bus_if.entry_req) begin
                enqueue(1'b0, 3'd0);
            end else if (bus_if.exit_req) begin
                enqueue(1'b1, bus_if.exit_token);
            end
        end
        m_tlast = m_time;
        if (reset_n === 1'b1 && tick === 1'b1) m_time = (m_time + 1) % 256;
        if (done) begin
            chk("response_count", 32'(resp_idx), 32'(N_RESP));
            chk("queue_drained",  32'(q.size()), 0);
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
        if (cyc > 20000) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: got cycle %0d, expected end before 20000", cyc);
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input bit e, input bit x, input logic [2:0] tok);
        bus_if.entry_req  = e;
        bus_if.exit_req   = x;
        bus_if.exit_token = tok;
        step();
        bus_if.entry_req  = 1'b0;
        bus_if.exit_req   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n           = 1'b0;
        tick              = 1'b0;
        bus_if.entry_req  = 1'b0;
        bus_if.exit_req   = 1'b0;
        bus_if.exit_token = 3'd0;
        bus_if.pattern    = 3'b101;
        idle(3);
        reset_n = 1'b1;

        // Three spaced entries, then fill up and overflow
        repeat (3) begin pulse(1'b1, 1'b0, 3'd0); idle(3); end
        repeat (6) begin pulse(1'b1, 1'b0, 3'd0); idle(3); end

        // Enter at time 10, leave 25 ticks later
        do_reset();
        bus_if.pattern = 3'd0;
        tick = 1'b1; idle(10); tick = 1'b0;
        pulse(1'b1, 1'b0, 3'd0); idle(3);
        tick = 1'b1; idle(25); tick = 1'b0;
        pulse(1'b0, 1'b1, 3'd0); idle(3);

        // Exit with a token pointing at an empty slot
        pulse(1'b1, 1'b0, 3'd0); idle(3);
        pulse(1'b0, 1'b1, 3'd3); idle(3);

        // Simultaneous requests, twice, to see the priority rotate
        do_reset();
        pulse(1'b1, 1'b1, 3'd0); idle(6);
        pulse(1'b1, 1'b1, 3'd0); idle(6);

        // Time counter wrap, then reset while an entry is in service
        do_reset();
        tick = 1'b1; idle(250); tick = 1'b0;
        pulse(1'b1, 1'b0, 3'd0); idle(3);
        tick = 1'b1; idle(10); tick = 1'b0;
        pulse(1'b0, 1'b1, 3'd0); idle(3);
        pulse(1'b1, 1'b0, 3'd0); idle(1);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(8);
        done = 1'b1;
        idle(4);
    end

endmodule

// File: doc/parking_access_controller.md
Name: parking_access_controller

Overview:
- Sequential controller that sequences the smart parking datapath.
- Arbitrates entry and exit gate requests onto a single allocation/release engine and owns the 8-slot occupancy register.
- Issues pattern-scrambled tokens, timestamps each parked car and reports parking duration on exit.
- Sits above the slot-allocation, token, capacity-count and time-calculation logic and replaces their static wiring with a clocked, handshaked flow.

Parameters:
- TIME_W, 8: width of the free-running time counter, stored entry times and time_total.
- PRIO_INIT, 0: initial round-robin priority after reset; 0 = entry first, 1 = exit first.
- FEE_RATE, 3: fee units per time unit; used only when SMART_PARKING_FEE_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  time-base strobe; time counter increments on each clk edge where tick=1.
- entry_req  in  1  single-cycle entry request pulse.
- exit_req  in  1  single-cycle exit request pulse.
- exit_token  in  3  token presented at exit; sampled in the same cycle as exit_req.
- pattern  in  3  scramble pattern; sampled when an entry or exit is serviced.
- busy  out  1  1 when state != IDLE.
- resp_valid  out  1  one-cycle response strobe.
- resp_type  out  1  0 = entry response, 1 = exit response.
- resp_ok  out  1  1 = request succeeded.
- token_out  out  3  issued token; valid with an entry response.
- time_total  out  TIME_W  parked duration; valid with an exit response.
- occupancy  out  8  slot bitmap, 1 = occupied.
- parked  out  4  popcount of occupancy.
- empty  out  4  8 - parked.
- fee  out  12  parking fee; present only with SMART_PARKING_FEE_EN.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; occupancy=0; parked=0; empty=8.
  - time counter=0; all stored entry times=0.
  - Pending flags cleared; priority=PRIO_INIT.
  - resp_valid, resp_type, resp_ok, token_out, time_total, fee all 0.
  - Reset mid-operation aborts the in-flight request with no response and discards pending requests.
- Request capture:
  - entry_req sets pending_entry at the clock edge; exit_req sets pending_exit and latches exit_token.
  - Capture happens in any state, including while busy.
  - A pulse arriving while the same flag is already set is merged. For exit, the newer token overwrites the latched one.
- FSM states: IDLE, ENTRY, EXIT, RESP.
  - IDLE: no pending flag → stay in IDLE.
    - One flag pending → go to ENTRY or EXIT.
    - Both pending → go to the one selected by priority, then toggle priority.
    - The serviced pending flag is cleared on the transition.
  - ENTRY: if occupancy=8'hFF → resp_ok=0, token_out=0.
    - Otherwise take slot s = lowest-index 0 bit. Set occupancy[s], store the time counter value as entry_time[s], token_out = s XOR pattern, resp_ok=1.
    - Go to RESP.
  - EXIT: slot s = latched exit_token XOR pattern.
    - occupancy[s]=1 → clear it, time_total = (time counter - entry_time[s]) mod 2^TIME_W, resp_ok=1.
    - Otherwise resp_ok=0, time_total=0, occupancy unchanged.
    - Go to RESP.
  - RESP: resp_valid=1 for exactly this cycle; response fields hold their values until the next response. Go to IDLE.
- Latency: request pulse in cycle 0 with the controller idle → resp_valid in cycle 3.
- Throughput: at most one response per 3 cycles.
- Counts: parked and empty are registered. They reflect occupancy in the same cycle occupancy updates, i.e. the cycle resp_valid is high.
- Time counter wraps from 2^TIME_W-1 to 0. The duration subtraction is modulo, so a wrapped exit still yields the correct elapsed value.
- tick and a service in the same cycle: the stored or subtracted time is the pre-increment value.

Optional Feature:
- SMART_PARKING_FEE_EN defined:
  - fee port exists.
  - On a successful exit, fee = min(time_total*FEE_RATE, 4095), registered alongside time_total.
  - fee = 0 on failed exits, entry responses and reset.
- Undefined: no fee port and no multiplier logic; all other behaviour identical.

Test Plan:
- Reset, then 3 entry pulses (pattern=3'b101, one every 4 cycles) → tokens 5, 4, 7; occupancy=8'h07; parked=3; empty=5; each resp_valid exactly 3 cycles after its request.
- 8 entries, then a 9th → 9th response has resp_ok=0, token_out=0; occupancy stays 8'hFF; parked=8, empty=0.
- Enter at time 10 (slot 0, pattern=0); 25 ticks later exit with token 0 → resp_ok=1, time_total=25, occupancy[0]=0; with SMART_PARKING_FEE_EN, fee=75.
- Exit with a token mapping to an empty slot → resp_type=1, resp_ok=0, time_total=0, occupancy unchanged.
- entry_req and exit_req in the same cycle after reset (PRIO_INIT=0) → entry response first, exit response 3 cycles later; a repeat collision then serves exit first.
- Enter at time 250 (TIME_W=8), exit at time 4 after wrap → time_total=10; assert reset_n low during ENTRY → no resp_valid, occupancy=0.
